// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses starting at BASE_ADDR.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_din,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t      state, nxt;
  logic [15:0] nw_q;
  logic [1:0]  idx;
  logic [15:0] wr_cnt_nxt;
  logic        xfer;

  assign wr_cnt_nxt = words_written + 16'd1;
  assign xfer       = (state == COLLECT) && byte_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (num_words == 16'd0) ? DONE : COLLECT;
      COLLECT: if (byte_valid && idx == 2'd3) nxt = WRITE;
      WRITE:   nxt = (wr_cnt_nxt == nw_q) ? DONE : COLLECT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign byte_ready = (state == COLLECT);
  assign im_we      = (state == WRITE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Address advances only on leaving WRITE, so it is stable during the strobe
  // and holds the last written address once the load finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_addr       <= BASE_ADDR;
      im_din        <= 32'd0;
      words_written <= 16'd0;
      idx           <= 2'd0;
      nw_q          <= 16'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nw_q          <= num_words;
          im_addr       <= BASE_ADDR;
          words_written <= 16'd0;
          idx           <= 2'd0;
        end
        COLLECT: if (xfer) begin
          case (idx)
            2'd0: im_din[31:24] <= byte_data;
            2'd1: im_din[23:16] <= byte_data;
            2'd2: im_din[15:8]  <= byte_data;
            default: im_din[7:0] <= byte_data;
          endcase
          idx <= idx + 2'd1;
        end
        WRITE: begin
          words_written <= wr_cnt_nxt;
          if (wr_cnt_nxt != nw_q) im_addr <= im_addr + 16'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: reset values, table-driven loads, randomized loads
// checked against a word-list model, reset mid-load and address wrap.
module tb_im_loader;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          n;
    int          first;
    int          gap;
    int          lat;
    logic [15:0] last_addr;
    logic [31:0] last_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [15:0] num_words = 16'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;

  logic        br1, we1, busy1, done1;
  logic [15:0] addr1, ww1;
  logic [31:0] din1;
  logic        br2, we2, busy2, done2;
  logic [15:0] addr2, ww2;
  logic [31:0] din2;

  im_loader dut (
    .clk(clk), .rst(rst), .start(start1), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br1),
    .im_we(we1), .im_addr(addr1), .im_din(din1), .busy(busy1),
    .done(done1), .words_written(ww1)
  );

  im_loader #(.BASE_ADDR(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br2),
    .im_we(we2), .im_addr(addr2), .im_din(din2), .busy(busy2),
    .done(done2), .words_written(ww2)
  );

  wire        ready_m = sel ? br2   : br1;
  wire        we_m    = sel ? we2   : we1;
  wire        done_m  = sel ? done2 : done1;
  wire        busy_m  = sel ? busy2 : busy1;
  wire [15:0] addr_m  = sel ? addr2 : addr1;
  wire [31:0] din_m   = sel ? din2  : din1;
  wire [15:0] ww_m    = sel ? ww2   : ww1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int done_cnt = 0;
  int t_done = -1;

  always @(negedge clk) begin
    if (we_m) begin
      wa_q.push_back(addr_m);
      wd_q.push_back(din_m);
    end
    if (done_m) begin
      if (done_cnt == 0) t_done = cyc;
      done_cnt++;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bq_t ramp(input int first, input int cnt);
    bq_t q;
    for (int i = 0; i < cnt; i++) q.push_back(8'((first + i) & 255));
    return q;
  endfunction

  // Model: word w goes to base+4w (mod 2^16), bytes 4w..4w+3 MSB first.
  task automatic do_load(input bit s, input int n, input bq_t bytes,
                         input int gapmode, input int restart_at, input int exp_lat);
    logic [15:0] base;
    int idx, k, t_start, lat;
    bit xfer;
    base = s ? 16'hFFFC : 16'h3000;
    sel = s;
    @(posedge clk); #1;
    wa_q.delete(); wd_q.delete(); done_cnt = 0; t_done = -1;
    num_words = 16'(n);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    num_words = 16'($urandom);
    idx = 0; k = 0;
    while (done_cnt == 0 && k < 2000) begin
      case (gapmode)
        0: byte_valid = 1'b1;
        1: byte_valid = (k % 2 == 0);
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      byte_data = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
      if (k == restart_at) begin
        if (s) start2 = 1'b1; else start1 = 1'b1;
      end
      xfer = byte_valid && ready_m;
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      if (xfer) idx++;
      k++;
    end
    byte_valid = 1'b0;
    if (k >= 2000) chk("done_timeout", 32'(done_cnt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    lat = t_done - t_start;
    chk("write_count", 32'(wa_q.size()), 32'(n));
    for (int w = 0; w < n && w < wa_q.size(); w++) begin
      chk("write_addr", 32'(wa_q[w]), 32'(16'(base + 16'(4 * w))));
      chk("write_data", wd_q[w], {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]});
    end
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("words_written", 32'(ww_m), 32'(n));
    chk("busy_idle", 32'(busy_m), 32'd0);
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    if (gapmode == 1 && n > 0) chk("gap_delayed", 32'(lat > 5 * n + 1), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{10, 8'h00, 0, 51, 16'h3024, 32'h24252627};
    vecs[1] = '{10, 8'h00, 1, -1, 16'h3024, 32'h24252627};
    vecs[2] = '{0,  8'h00, 0, 1,  16'h0000, 32'h0};
    vecs[3] = '{1,  8'h10, 0, 6,  16'h3000, 32'h10111213};
    vecs[4] = '{3,  8'hF0, 0, 16, 16'h3008, 32'hF8F9FAFB};

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_ready", 32'(br1), 32'd0);
    chk("rst_im_we", 32'(we1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_im_din", din1, 32'd0);
    chk("rst_im_addr", 32'(addr1), 32'h3000);
    chk("rst_words", 32'(ww1), 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      do_load(1'b0, vecs[v].n, ramp(vecs[v].first, 4 * vecs[v].n),
              vecs[v].gap, -1, vecs[v].lat);
      if (vecs[v].n > 0) begin
        chk("last_addr", 32'(wa_q[wa_q.size()-1]), 32'(vecs[v].last_addr));
        chk("last_data", wd_q[wd_q.size()-1], vecs[v].last_data);
        chk("addr_held", 32'(addr1), 32'(vecs[v].last_addr));
      end
    end

    // Reset after 2 bytes of the first word
    @(posedge clk); #1;
    wa_q.delete(); wd_q.delete(); sel = 1'b0;
    num_words = 16'd1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
    @(posedge clk); #1;
    byte_data = 8'hBB;
    @(posedge clk); #1;
    byte_valid = 1'b0; rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_im_we", 32'(we1), 32'd0);
    chk("midrst_din", din1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_write", 32'(wa_q.size()), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_wait", 32'(busy1), 32'd0);
    do_load(1'b0, 1, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0, -1, 6);
    if (wd_q.size() > 0) chk("deadbeef", wd_q[0], 32'hDEADBEEF);

    // Address wrap with a stray start mid-load
    do_load(1'b1, 2, ramp(8'h40, 8), 0, 3, 11);
    if (wa_q.size() == 2) begin
      chk("wrap_addr0", 32'(wa_q[0]), 32'h0000FFFC);
      chk("wrap_addr1", 32'(wa_q[1]), 32'h00000000);
    end

    // Randomized loads against the model
    for (int r = 0; r < 6; r++) begin
      int n;
      bq_t b;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
      do_load(1'(r % 2), n, b, 2,
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 6)) : -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The block SHALL have a parameter BASE_ADDR, default 16'h3000, which is the byte address of the first word written (code segment start).
REQ-002 The block SHALL have a clk input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a rst input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a start input, 1 bit: single-cycle request to begin a load.
REQ-005 The block SHALL have a num_words input, 16 bits: the number of words to load, sampled only when start is accepted.
REQ-006 The block SHALL have a byte_valid input, 1 bit: the source presents byte_data.
REQ-007 The block SHALL have a byte_data input, 8 bits: the incoming byte.
REQ-008 The block SHALL have a byte_ready output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have an im_we output, 1 bit: the instruction memory write strobe.
REQ-010 The block SHALL have an im_addr output, 16 bits: the byte address, word-aligned.
REQ-011 The block SHALL have an im_din output, 32 bits: the write data.
REQ-012 The block SHALL have a busy output, 1 bit: a load is in progress.
REQ-013 The block SHALL have a done output, 1 bit: a one-cycle pulse at load completion.
REQ-014 The block SHALL have a words_written output, 16 bits: the count of words written in the current or last load.

Function
REQ-015 The block SHALL implement exactly the states IDLE, COLLECT, WRITE and DONE.
REQ-016 In IDLE, byte_ready=0 and im_we=0; the block SHALL act on start=1 as follows:
- num_words>0: go to COLLECT; im_addr=BASE_ADDR, byte index=0, words_written=0.
- num_words=0: go to DONE; im_we is never asserted.
REQ-017 In COLLECT, byte_ready SHALL be 1; a transfer occurs only on a cycle where byte_valid=1 and byte_ready=1.
REQ-018 Byte assembly SHALL be big-endian: transfer k (0..3) of a word is written to im_din[31-8k:24-8k], so bytes 00,01,02,03 form 32'h00010203.
REQ-019 On the 4th transfer of a word, the state SHALL be WRITE on the next cycle.
REQ-020 In WRITE, the block SHALL:
- assert im_we=1 for exactly one cycle with the stable im_addr and im_din of that word;
- hold byte_ready=0.
REQ-021 On leaving WRITE, words_written SHALL increment; if it then equals num_words, the next state is DONE, otherwise im_addr increments by 4 and the next state is COLLECT.
REQ-022 im_addr SHALL wrap modulo 2^16 (16'hFFFC+4 = 16'h0000).
REQ-023 In DONE, done=1 for one cycle and the next state SHALL be IDLE.
REQ-024 busy SHALL be 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored whenever the state is not IDLE.
REQ-026 im_addr, im_din and words_written SHALL hold their last values in IDLE.
REQ-027 Minimum cost SHALL be 5 cycles per word with byte_valid held at 1: 4 transfers plus 1 write.
REQ-028 Gaps in byte_valid SHALL stall COLLECT only and SHALL NOT corrupt the assembled data.

Reset
REQ-029 While rst=0, asynchronously, the block SHALL force the state to IDLE and drive byte_ready=0, im_we=0, busy=0, done=0, im_din=0, im_addr=BASE_ADDR, words_written=0 and byte index=0.
REQ-030 On reset during a load, the block SHALL discard any partial word and perform no write; after release the block waits for a new start.

Verification
REQ-031 A bench SHALL cover: rst low for 3 cycles -> all outputs at their reset values, im_addr=16'h3000.
REQ-032 A bench SHALL cover: start, num_words=10, bytes 8'h00..8'h27 with byte_valid held at 1 -> ten im_we pulses writing 32'h00010203 at 16'h3000, rising by 32'h04040404 per word up to 32'h24252627 at 16'h3024; exactly one done pulse; words_written=10; done 51 cycles after start.
REQ-033 A bench SHALL cover: the same stream with byte_valid low every other cycle -> identical write addresses and data, completion delayed.
REQ-034 A bench SHALL cover: start with num_words=0 -> done pulse on the next cycle, im_we never asserted, words_written=0.
REQ-035 A bench SHALL cover: rst asserted after 2 bytes of the first word -> no im_we, busy=0 immediately; a subsequent start with num_words=1 and bytes DE AD BE EF -> 32'hDEADBEEF written at 16'h3000.
REQ-036 A bench SHALL cover: BASE_ADDR=16'hFFFC, num_words=2, plus a start pulse mid-load -> writes at 16'hFFFC then 16'h0000, the second start ignored, one done pulse.
